// File: rtl/freq_div_if.sv
// Output bundle of freq_div: divided square wave and, when FREQ_DIV_TICK_EN
// is defined, the once-per-period rising-edge tick.
`timescale 1ns/1ps
interface freq_div_if;
  logic clk_out;
`ifdef FREQ_DIV_TICK_EN
  logic tick;
  modport master (output clk_out, output tick);
  modport slave  (input  clk_out, input  tick);
`else
  modport master (output clk_out);
  modport slave  (input  clk_out);
`endif
endinterface

// File: rtl/freq_div.sv
// freq_div: divides clk down to a 50 % duty square wave of OUT_FREQ_HZ.
// clk_out toggles every HALF_CNT edges; it is a plain flop output, not a clock.
// Reset is asserted asynchronously and released through a 2-flop synchroniser:
// the synchronised release lands on the 2nd clk edge after rst_n rises, and
// counting edges are the ones that follow. The first 0->1 toggle happens on the
// HALF_CNT-th counting edge.
// Optional feature macro: FREQ_DIV_TICK_EN adds a one-cycle tick on each
// clk_out rising edge (port carried in freq_div_if).
`timescale 1ns/1ps
module freq_div #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int OUT_FREQ_HZ = 1_000
) (
  input  logic          clk,
  input  logic          rst_n,
  freq_div_if.master    o
);

  // Rounded half period; guarded against divide-by-zero so the fatal check
  // below is what reports a bad configuration.
  localparam int HALF_CNT = (OUT_FREQ_HZ == 0) ? 1
                          : (CLK_FREQ_HZ + OUT_FREQ_HZ) / (2 * OUT_FREQ_HZ);
  localparam int CNT_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_CNT - 1);

  if (OUT_FREQ_HZ == 0) begin : g_bad_out
    $fatal(1, "freq_div: OUT_FREQ_HZ must be non-zero");
  end
  if (CLK_FREQ_HZ < 2 * OUT_FREQ_HZ) begin : g_bad_ratio
    $fatal(1, "freq_div: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
  end

  logic [1:0]       rst_sync;
  logic             run;
  logic [CNT_W-1:0] cnt;
  logic             clk_out_q;

  // Reset synchroniser: async assert, release after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  // Half-period counter with explicit wrap; clk_out flips on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      clk_out_q <= 1'b0;
    end else if (run) begin
      if (cnt == CNT_MAX) begin
        cnt       <= '0;
        clk_out_q <= ~clk_out_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign o.clk_out = clk_out_q;

`ifdef FREQ_DIV_TICK_EN
  logic tick_q;

  // Tick fires on the same edge clk_out goes 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= run && (cnt == CNT_MAX) && !clk_out_q;
  end

  assign o.tick = tick_q;
`endif

endmodule

// File: tb/tb_freq_div.sv
// Bench for freq_div: default (27 MHz -> 1 kHz), small (HALF_CNT=5) and
// boundary (HALF_CNT=1) instances run side by side on one clock. Expected
// outputs come from edge counts since reset release using plain arithmetic.
`timescale 1ns/1ps
module tb_freq_div;

  localparam int HD = 13500;  // (27e6+1e3)/2e3
  localparam int HS = 5;      // (10+1)/2
  localparam int HB = 1;      // (2+1)/2

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;  // default + boundary instances
  logic rst_n_s = 1'b0;  // small instance, used for mid-run resets

  int n_chk = 0;
  int n_err = 0;
  bit done  = 1'b0;

  int ka = 0;  // clk edges since rst_n_a release
  int ks = 0;  // clk edges since rst_n_s release

  freq_div_if if_a ();
  freq_div_if if_s ();
  freq_div_if if_b ();

  freq_div #(.CLK_FREQ_HZ(27_000_000), .OUT_FREQ_HZ(1_000)) dut_a (.clk(clk), .rst_n(rst_n_a), .o(if_a));
  freq_div #(.CLK_FREQ_HZ(10),         .OUT_FREQ_HZ(1))     dut_s (.clk(clk), .rst_n(rst_n_s), .o(if_s));
  freq_div #(.CLK_FREQ_HZ(2),          .OUT_FREQ_HZ(1))     dut_b (.clk(clk), .rst_n(rst_n_a), .o(if_b));

  always #18.5 clk = ~clk;  // ~27 MHz

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: edges 1 and 2 after release are synchroniser edges, the rest
  // count. Output is the parity of completed half periods.
  function automatic int n_cnt(input int k);
    return (k > 2) ? k - 2 : 0;
  endfunction
  function automatic int exp_out(input int k, input int h);
    return (n_cnt(k) / h) % 2;
  endfunction
  function automatic int exp_cnt(input int k, input int h);
    return n_cnt(k) % h;
  endfunction
  function automatic int exp_tick(input int k, input int h);
    int n;
    n = n_cnt(k);
    return (n > 0 && n % h == 0 && (n / h) % 2 == 1) ? 1 : 0;
  endfunction

  // Edge counters for the model.
  always @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) ka <= 0; else ka <= ka + 1;
  always @(posedge clk or negedge rst_n_s)
    if (!rst_n_s) ks <= 0; else ks <= ks + 1;

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (!done) begin
      chk("def_out", 32'(if_a.clk_out), 32'(exp_out(ka, HD)));
      chk("small_out", 32'(if_s.clk_out), 32'(exp_out(ks, HS)));
      chk("bound_out", 32'(if_b.clk_out), 32'(exp_out(ka, HB)));
`ifdef FREQ_DIV_TICK_EN
      chk("def_tick", 32'(if_a.tick), 32'(exp_tick(ka, HD)));
      chk("small_tick", 32'(if_s.tick), 32'(exp_tick(ks, HS)));
      chk("bound_tick", 32'(if_b.tick), 32'(exp_tick(ka, HB)));
`endif
    end
  end

  // Level-length measurement on the default instance.
  int   tog_a  = 0;
  int   last_a = 0;
  logic prev_a = 1'b0;
  always @(negedge clk) begin
    if (!done && if_a.clk_out !== prev_a) begin
      tog_a++;
      if (tog_a == 1) begin
        chk("def_first_rise_edge", 32'(ka), 32'(HD + 2));
        chk("def_first_level", 32'(if_a.clk_out), 32'd1);
      end else begin
        chk("def_level_len", 32'(ka - last_a), 32'(HD));
      end
      last_a = ka;
    end
    prev_a = if_a.clk_out;
  end

  // Watchdog: the run must not outlive its cycle budget.
  initial begin
    #(37.0 * 70000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    // Reset hold.
    repeat (100) @(negedge clk);
    chk("hold_toggles", 32'(tog_a), 32'd0);
    chk("hold_small_out", 32'(if_s.clk_out), 32'd0);
    rst_n_a = 1'b1;
    rst_n_s = 1'b1;

    // Random mid-run resets on the small instance; even iterations aim for
    // the high phase with cnt==3.
    for (int it = 0; it < 16; it++) begin
      int w;
      repeat ($urandom_range(3, 30)) @(negedge clk);
      if (it % 2 == 0) begin
        w = 0;
        while (!(exp_out(ks, HS) == 1 && exp_cnt(ks, HS) == 3) && w < 40) begin
          @(negedge clk);
          w++;
        end
        chk("small_phase_found", 32'(w < 40), 32'd1);
      end
      #($urandom_range(1, 15));
      rst_n_s = 1'b0;
      #1;
      chk("small_async_clr", 32'(if_s.clk_out), 32'd0);
`ifdef FREQ_DIV_TICK_EN
      chk("small_async_tick", 32'(if_s.tick), 32'd0);
`endif
      repeat ($urandom_range(1, 5)) @(negedge clk);
      rst_n_s = 1'b1;
    end

    // Let the default instance cover two full output periods.
    while (ka < 56000) @(negedge clk);
    chk("def_toggle_count", 32'(tog_a), 32'd4);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
